// File: rtl/core_seq_pkg.sv
// Shared definitions for the multi-cycle RV32I core sequencer: state codes,
// active-low enable levels and the default memory wait limit.
package core_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic EN_ACTIVE = 1'b0;
  localparam logic EN_IDLE   = 1'b1;

  localparam int DEFAULT_MEM_TIMEOUT = 255;

  // Loads and stores both visit MEM; everything else goes straight to WB.
  function automatic logic is_mem_op(input logic mem_wEn, input logic wb_sel);
    return (mem_wEn == EN_ACTIVE) || wb_sel;
  endfunction

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Wait-cycle counter shared by the FETCH and MEM handshakes; flags expiry once
// TIMEOUT consecutive not-ready cycles have been counted.
module mem_wait_timer
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// phase-gated write enables, retired-instruction counter and timeout trap.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_req,
  input  logic             dec_wEn,
  input  logic             dec_mem_wEn,
  input  logic             dec_wb_sel,
  input  logic             dec_branch_op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_wEn,
  output logic             ir_wEn,
  output logic             pc_wEn,
  output logic             rf_wEn,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             err
);

  // Handshake: a request stays high while its state persists; ready is only
  // acted on in the state that owns the request and is ignored elsewhere.

  logic [2:0] state_q, state_d;
  logic       is_store, wait_en, expired, retire;

  // The branch flag only selects the PC source in the datapath; the sequencer
  // updates the PC for every retiring instruction.
  logic unused_branch_op;
  assign unused_branch_op = dec_branch_op;

  assign is_store = (dec_mem_wEn == EN_ACTIVE);
  assign wait_en  = ((state_q == S_FETCH) && !imem_ready) ||
                    ((state_q == S_MEM)   && !dmem_ready);
  assign retire   = (state_q == S_WB) ||
                    ((state_q == S_MEM) && dmem_ready && is_store);

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!wait_en),
    .en      (wait_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = halt_req ? S_HALT : S_FETCH;
      S_FETCH: begin
        if (imem_ready)   state_d = S_DECODE;
        else if (expired) state_d = S_ERROR;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_mem_op(dec_mem_wEn, dec_wb_sel) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          if (is_store) state_d = halt_req ? S_HALT : S_FETCH;
          else          state_d = S_WB;
        end else if (expired) begin
          state_d = S_ERROR;
        end
      end
      S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_ERROR;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_wEn = EN_IDLE;
    ir_wEn   = 1'b0;
    rf_wEn   = EN_IDLE;
    pc_wEn   = retire;
    state    = state_q;
    halted   = (state_q == S_HALT);
    err      = (state_q == S_ERROR);
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_wEn   = imem_ready;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_wEn = dec_mem_wEn;
      end
      S_WB:    rf_wEn = dec_wEn;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle vector table for ALU, load,
// store, halt and reset flows, plus hand sequences for timeout and wrap.
module tb_core_sequencer;
  import core_seq_pkg::*;

  localparam int CNT_W = 3;
  localparam int OW    = 11 + CNT_W;

  logic             clk, rst_n, halt_req;
  logic             dec_wEn, dec_mem_wEn, dec_wb_sel, dec_branch_op;
  logic             imem_ready, dmem_ready;
  logic             imem_req, dmem_req, dmem_wEn, ir_wEn, pc_wEn, rf_wEn;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;
  logic             halted, err;

  core_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .dec_wEn(dec_wEn), .dec_mem_wEn(dec_mem_wEn), .dec_wb_sel(dec_wb_sel),
    .dec_branch_op(dec_branch_op), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_wEn(dmem_wEn),
    .ir_wEn(ir_wEn), .pc_wEn(pc_wEn), .rf_wEn(rf_wEn), .state(state),
    .instret(instret), .halted(halted), .err(err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rst_n, halt, wen, mwen, wbsel, ir, dr;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [OW-1:0] pk(input logic [2:0] st, input logic ireq, dreq,
                                       dwen, irw, pcw, rfw, hlt, er,
                                       input logic [CNT_W-1:0] ins);
    return {st, ireq, dreq, dwen, irw, pcw, rfw, hlt, er, ins};
  endfunction

  function automatic logic [OW-1:0] actual();
    return {state, imem_req, dmem_req, dmem_wEn, ir_wEn, pc_wEn, rf_wEn, halted, err, instret};
  endfunction

  // driver tasks
  task automatic v(input logic r, h, we, mwe, wbs, ir, dr, input logic [OW-1:0] e);
    vec_t x;
    x.rst_n = r; x.halt = h; x.wen = we; x.mwen = mwe; x.wbsel = wbs;
    x.ir = ir; x.dr = dr; x.exp = e;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, h, we, mwe, wbs, ir, dr);
    rst_n = r; halt_req = h; dec_wEn = we; dec_mem_wEn = mwe;
    dec_wb_sel = wbs; imem_ready = ir; dmem_ready = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int fetch_cycles;
    logic [OW-1:0] e;

    dec_branch_op = 1'b0;
    drive(0, 0, 0, 1, 0, 1, 0);

    // reset, then ADD with zero-wait fetch
    v(0,0,0,1,0,1,0, pk(S_IDLE,  0,0,1,0,0,1,0,0,0));
    v(1,0,0,1,0,1,0, pk(S_IDLE,  0,0,1,0,0,1,0,0,0));
    v(1,0,0,1,0,1,0, pk(S_FETCH, 1,0,1,1,0,1,0,0,0));
    v(1,0,0,1,0,1,0, pk(S_DECODE,0,0,1,0,0,1,0,0,0));
    v(1,0,0,1,0,1,0, pk(S_EXEC,  0,0,1,0,0,1,0,0,0));
    v(1,0,0,1,0,1,0, pk(S_WB,    0,0,1,0,1,0,0,0,0));
    // load, dmem_ready after 3 wait cycles
    v(1,0,0,1,1,1,0, pk(S_FETCH, 1,0,1,1,0,1,0,0,1));
    v(1,0,0,1,1,1,0, pk(S_DECODE,0,0,1,0,0,1,0,0,1));
    v(1,0,0,1,1,1,0, pk(S_EXEC,  0,0,1,0,0,1,0,0,1));
    v(1,0,0,1,1,1,0, pk(S_MEM,   0,1,1,0,0,1,0,0,1));
    v(1,0,0,1,1,1,0, pk(S_MEM,   0,1,1,0,0,1,0,0,1));
    v(1,0,0,1,1,1,0, pk(S_MEM,   0,1,1,0,0,1,0,0,1));
    v(1,0,0,1,1,1,1, pk(S_MEM,   0,1,1,0,0,1,0,0,1));
    v(1,0,0,1,1,1,0, pk(S_WB,    0,0,1,0,1,0,0,0,1));
    // store with one fetch wait; stray dmem_ready outside MEM ignored
    v(1,0,1,0,0,0,0, pk(S_FETCH, 1,0,1,0,0,1,0,0,2));
    v(1,0,1,0,0,1,0, pk(S_FETCH, 1,0,1,1,0,1,0,0,2));
    v(1,0,1,0,0,1,1, pk(S_DECODE,0,0,1,0,0,1,0,0,2));
    v(1,0,1,0,0,1,1, pk(S_EXEC,  0,0,1,0,0,1,0,0,2));
    v(1,0,1,0,0,1,0, pk(S_MEM,   0,1,0,0,0,1,0,0,2));
    v(1,0,1,0,0,1,1, pk(S_MEM,   0,1,0,0,1,1,0,0,2));
    // ADD, halt_req raised mid-instruction, taken at WB
    v(1,0,0,1,0,1,0, pk(S_FETCH, 1,0,1,1,0,1,0,0,3));
    v(1,1,0,1,0,1,0, pk(S_DECODE,0,0,1,0,0,1,0,0,3));
    v(1,1,0,1,0,1,0, pk(S_EXEC,  0,0,1,0,0,1,0,0,3));
    v(1,1,0,1,0,1,0, pk(S_WB,    0,0,1,0,1,0,0,0,3));
    v(1,0,0,1,0,1,0, pk(S_HALT,  0,0,1,0,0,1,1,0,4));
    v(1,0,0,1,0,1,0, pk(S_HALT,  0,0,1,0,0,1,1,0,4));
    v(0,0,0,1,0,1,0, pk(S_HALT,  0,0,1,0,0,1,1,0,4));
    // reset mid-MEM on a load
    v(1,0,0,1,1,1,0, pk(S_IDLE,  0,0,1,0,0,1,0,0,0));
    v(1,0,0,1,1,1,0, pk(S_FETCH, 1,0,1,1,0,1,0,0,0));
    v(1,0,0,1,1,1,0, pk(S_DECODE,0,0,1,0,0,1,0,0,0));
    v(1,0,0,1,1,1,0, pk(S_EXEC,  0,0,1,0,0,1,0,0,0));
    v(0,0,0,1,1,1,0, pk(S_MEM,   0,1,1,0,0,1,0,0,0));
    v(1,0,0,1,0,0,0, pk(S_IDLE,  0,0,1,0,0,1,0,0,0));

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].halt, vecs[i].wen, vecs[i].mwen,
            vecs[i].wbsel, vecs[i].ir, vecs[i].dr);
      exp_q.push_back(vecs[i].exp);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d", i), 32'(actual()), 32'(e));
      tick();
    end

    // imem_ready stuck low: 5 FETCH cycles, then ERROR
    fetch_cycles = 0;
    for (int i = 0; i < 20 && state == S_FETCH; i++) begin
      fetch_cycles++;
      tick();
    end
    chk("timeout_fetch_cycles", 32'(fetch_cycles), 32'd5);
    chk("timeout_state", 32'(state), 32'(S_ERROR));
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_imem_req", 32'(imem_req), 32'd0);
    imem_ready = 1'b1;
    repeat (3) tick();
    chk("error_absorbing", 32'(state), 32'(S_ERROR));
    rst_n = 1'b0;
    halt_req = 1'b1;
    tick();
    chk("error_reset_state", 32'(state), 32'(S_IDLE));
    chk("error_reset_err", 32'(err), 32'd0);

    // halt requested while idle
    rst_n = 1'b1;
    tick();
    chk("idle_halt_state", 32'(state), 32'(S_HALT));
    chk("idle_halt_flag", 32'(halted), 32'd1);
    chk("idle_halt_no_req", 32'(imem_req), 32'd0);

    // instret wraps modulo 2^CNT_W after 8 ALU instructions
    rst_n = 1'b0;
    halt_req = 1'b0;
    tick();
    drive(1, 0, 0, 1, 0, 1, 0);
    tick();
    repeat (7 * 4) tick();
    chk("wrap_state", 32'(state), 32'(S_FETCH));
    chk("wrap_count7", 32'(instret), 32'd7);
    repeat (4) tick();
    chk("wrap_count0", 32'(instret), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
